// File: rtl/mem_pkg.sv
// Shared types for the byte-serial data-memory access unit: FSM states,
// access-size encoding and the size-to-byte-count helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  function automatic logic [2:0] byte_count(size_t sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-result extension: sign- or zero-extends a byte or
// halfword held in the low bits of the assembled buffer; words pass through.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] buffer,
  input  logic [1:0]  size,
  input  logic        unsign,
  output logic [31:0] ext_word
);

  always_comb begin
    ext_word = buffer;
    case (size_t'(size))
      SZ_B:    ext_word = {{24{~unsign & buffer[7]}}, buffer[7:0]};
      SZ_H:    ext_word = {{16{~unsign & buffer[15]}}, buffer[15:0]};
      default: ext_word = buffer;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-serial data-memory responder: serialises loads/stores onto an 8-bit bus
// and stalls the core via busy. Define MEM_MISALIGN_TRAP_EN to trap misaligned
// half/word accesses instead of performing them byte by byte.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              by,
  input  logic              half,
  input  logic              unsign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_re,
  output logic              bus_we,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ready
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  size_t             size_q, size_d;
  logic              unsign_q, unsign_d;
  logic              is_read_q, is_read_d;
  logic [1:0]        k_q, k_d;
  logic [31:0]       buffer_q, buffer_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_re_q, bus_re_d;
  logic              bus_we_q, bus_we_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;

  size_t             req_size;
  logic              req_valid;
  logic              mis_req;
  logic [1:0]        k_next;
  logic              last_byte;
  logic [31:0]       buffer_capt;
  logic [31:0]       ext_word;

  always_comb begin
    req_size  = by ? SZ_B : (half ? SZ_H : SZ_W);
    req_valid = start & (mem_read ^ mem_write);
`ifdef MEM_MISALIGN_TRAP_EN
    mis_req   = ((req_size == SZ_H) && addr[0]) ||
                ((req_size == SZ_W) && (addr[1:0] != 2'b00));
`else
    mis_req   = 1'b0;
`endif
    k_next    = k_q + 2'd1;
    last_byte = ({1'b0, k_q} == (byte_count(size_q) - 3'd1));
    buffer_capt = buffer_q;
    buffer_capt[{k_q, 3'b000} +: 8] = bus_rdata;
  end

  // Extension sees the buffer including the byte arriving this cycle, so
  // rdata is valid in the same cycle as done.
  load_extend u_load_extend (
    .buffer   (buffer_capt),
    .size     (size_q),
    .unsign   (unsign_q),
    .ext_word (ext_word)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    unsign_d    = unsign_q;
    is_read_d   = is_read_q;
    k_d         = k_q;
    buffer_d    = buffer_q;
    rdata_d     = rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_re_d    = 1'b0;
    bus_we_d    = 1'b0;
    done_d      = 1'b0;
    mis_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = addr;
          wdata_d   = wdata;
          size_d    = req_size;
          unsign_d  = unsign;
          is_read_d = mem_read;
          k_d       = '0;
          buffer_d  = '0;
          if (mis_req) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d     = ACCESS;
            bus_addr_d  = addr;
            bus_re_d    = mem_read;
            bus_we_d    = mem_write;
            bus_wdata_d = wdata[7:0];
          end
        end
      end
      ACCESS: begin
        bus_re_d = bus_re_q;
        bus_we_d = bus_we_q;
        if (bus_ready) begin
          if (is_read_q) buffer_d = buffer_capt;
          if (last_byte) begin
            state_d  = DONE;
            done_d   = 1'b1;
            bus_re_d = 1'b0;
            bus_we_d = 1'b0;
            if (is_read_q) rdata_d = ext_word;
          end else begin
            k_d         = k_next;
            bus_addr_d  = addr_q + ADDR_W'(k_next);
            bus_wdata_d = wdata_q[{k_next, 3'b000} +: 8];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_B;
      unsign_q    <= 1'b0;
      is_read_q   <= 1'b0;
      k_q         <= '0;
      buffer_q    <= '0;
      rdata_q     <= '0;
      bus_addr_q  <= '0;
      bus_re_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      unsign_q    <= unsign_d;
      is_read_q   <= is_read_d;
      k_q         <= k_d;
      buffer_q    <= buffer_d;
      rdata_q     <= rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_re_q    <= bus_re_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
    end
  end

  assign busy       = (state_q == ACCESS);
  assign rdata      = rdata_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign bus_addr   = bus_addr_q;
  assign bus_re     = bus_re_q;
  assign bus_we     = bus_we_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, corner sequences
// and randomized accesses against a byte-array memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        by = 1'b0, half = 1'b0, unsign = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, misaligned;
  logic [31:0] bus_addr;
  logic        bus_re, bus_we;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = '0;
  logic        bus_ready = 1'b0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .by(by), .half(half), .unsign(unsign),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .misaligned(misaligned), .bus_addr(bus_addr), .bus_re(bus_re),
    .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [7:0]  d;
  } ev_t;

  typedef struct packed {
    logic        rd, wr, b, h, u;
    logic [31:0] a, wd;
    logic [7:0]  waits;
    logic [31:0] lat;
    logic [31:0] rdata;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [7:0] bmem    [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  ev_t        log_q[$];
  int         wait_tab[4];
  int         byte_idx = 0;
  int         wait_cnt = 0;
  logic [31:0] model_rdata = '0;

  function automatic logic [7:0] init_byte(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] bus_byte(logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_byte(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // Expected load value: little-endian assembly, then arithmetic extension.
  function automatic logic [31:0] load_model(logic [31:0] a, int n, bit u);
    longint v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ref_byte(a + 32'(i))) << (8 * i);
    if (!u && n < 4 && v >= (64'sd1 << (8 * n - 1)))
      v -= (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  // Bus slave: programmable wait cycles per byte, logs every accepted byte.
  always @(negedge clk) begin
    bus_ready = 1'b0;
    if (rst_n && (bus_re || bus_we)) begin
      if (wait_cnt < wait_tab[byte_idx]) begin
        wait_cnt++;
      end else begin
        bus_ready = 1'b1;
        wait_cnt  = 0;
        if (bus_we) begin
          bmem[bus_addr] = bus_wdata;
          log_q.push_back('{a: bus_addr, we: 1'b1, d: bus_wdata});
        end else begin
          bus_rdata = bus_byte(bus_addr);
          log_q.push_back('{a: bus_addr, we: 1'b0, d: 8'h00});
        end
        byte_idx = (byte_idx + 1) % 4;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(vec_t v);
    return v.b ? 1 : (v.h ? 2 : 4);
  endfunction

  function automatic bit is_trap(vec_t v);
    bit mis;
    mis = (!v.b && v.h && v.a[0]) || (!v.b && !v.h && v.a[1:0] != 2'b00);
    return TRAP && mis;
  endfunction

  task automatic run_access(input vec_t v, input bit inj, input string tag);
    int n, lat;
    bit trap, got;
    logic [31:0] act_r, tmp;
    logic act_mis, act_busy;
    ev_t e;
    n    = nbytes(v);
    trap = is_trap(v);
    @(negedge clk);
    log_q.delete();
    byte_idx = 0;
    wait_cnt = 0;
    for (int i = 0; i < 4; i++) wait_tab[i] = int'(v.waits[2*i +: 2]);
    start = 1'b1; mem_read = v.rd; mem_write = v.wr;
    by = v.b; half = v.h; unsign = v.u; addr = v.a; wdata = v.wd;
    @(posedge clk);
    #1 start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    lat = 0; got = 1'b0;
    act_r = '0; act_mis = 1'b0; act_busy = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin start = 1'b0; mem_write = 1'b0; end
      if (done) begin
        got = 1'b1; act_r = rdata; act_mis = misaligned; act_busy = busy;
      end else begin
        if (lat == 1) chk({tag, " busy"}, 32'(busy), 32'(!trap));
        if (inj && lat == 1) begin
          start = 1'b1; mem_write = 1'b1; mem_read = 1'b0; addr = 32'h700;
        end
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done within %0d cycles, expected %0d", tag, lat, v.lat);
    end else begin
      if (inj) begin start = 1'b1; mem_read = 1'b1; by = 1'b1; addr = 32'h800; end
      @(posedge clk);
      #1 start = 1'b0; mem_read = 1'b0;
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(done), 32'd0);
      chk({tag, " idle_after"}, 32'(busy), 32'd0);
    end
    chk({tag, " latency"}, 32'(lat), v.lat);
    chk({tag, " busy_at_done"}, 32'(act_busy), 32'd0);
    chk({tag, " misaligned"}, 32'(act_mis), 32'(trap));
    chk({tag, " rdata"}, act_r, v.rdata);
    chk({tag, " nbytes"}, 32'(log_q.size()), trap ? 32'd0 : 32'(n));
    if (!trap) begin
      for (int i = 0; i < n && i < log_q.size(); i++) begin
        tmp = v.wd >> (8 * i);
        e = log_q[i];
        chk({tag, " bus_addr"}, e.a, v.a + 32'(i));
        chk({tag, " bus_dir_data"}, {23'd0, e.we, e.d},
            {23'd0, v.wr, v.wr ? tmp[7:0] : 8'h00});
      end
      if (v.wr) for (int i = 0; i < n; i++) begin
        tmp = v.wd >> (8 * i);
        ref_mem[v.a + 32'(i)] = tmp[7:0];
      end
      if (v.rd) model_rdata = v.rdata;
    end
  endtask

  function automatic vec_t mk(bit rd, bit b, bit h, bit u, logic [31:0] a,
                              logic [31:0] wd, logic [7:0] w, int lat,
                              logic [31:0] r);
    vec_t v;
    v.rd = rd; v.wr = !rd; v.b = b; v.h = h; v.u = u;
    v.a = a; v.wd = wd; v.waits = w; v.lat = 32'(lat); v.rdata = r;
    return v;
  endfunction

  task automatic preset(input logic [31:0] a, input logic [7:0] d);
    bmem[a] = d;
    ref_mem[a] = d;
  endtask

  vec_t tab[9];
  vec_t rv;

  initial begin
    for (int i = 0; i < 4; i++) wait_tab[i] = 0;
    preset(32'h103, 8'h80);
    preset(32'h200, 8'h34); preset(32'h201, 8'hF2);
    preset(32'hFFFFFFFE, 8'h11); preset(32'hFFFFFFFF, 8'h22);
    preset(32'h0, 8'h33); preset(32'h1, 8'h44);
    preset(32'h500, 8'h01); preset(32'h501, 8'h80);
    preset(32'h601, 8'hAA); preset(32'h602, 8'h7F);

    //       rd b  h  u  addr          wdata         waits  lat rdata
    tab[0] = mk(1, 1, 0, 0, 32'h103,      32'h0,        8'h00, 2, 32'hFFFFFF80);
    tab[1] = mk(1, 0, 1, 1, 32'h200,      32'h0,        8'h01, 4, 32'h0000F234);
    tab[2] = mk(0, 0, 0, 0, 32'h300,      32'hDEADBEEF, 8'h00, 5, 32'h0000F234);
    if (TRAP)
      tab[3] = mk(1, 0, 0, 0, 32'hFFFFFFFE, 32'h0,      8'h00, 1, 32'h0000F234);
    else
      tab[3] = mk(1, 0, 0, 0, 32'hFFFFFFFE, 32'h0,      8'h00, 5, 32'h44332211);
    tab[4] = mk(1, 0, 1, 0, 32'h500,      32'h0,        8'h00, 3, 32'hFFFF8001);
    tab[5] = mk(1, 1, 0, 1, 32'h501,      32'h0,        8'h00, 2, 32'h00000080);
    tab[6] = mk(1, 0, 0, 0, 32'h300,      32'h0,        8'h84, 8, 32'hDEADBEEF);
    tab[7] = mk(0, 1, 0, 0, 32'h600,      32'h12345678, 8'h00, 2, 32'hDEADBEEF);
    if (TRAP)
      tab[8] = mk(1, 0, 1, 0, 32'h601,    32'h0,        8'h00, 1, 32'hDEADBEEF);
    else
      tab[8] = mk(1, 0, 1, 0, 32'h601,    32'h0,        8'h00, 3, 32'h00007FAA);

    repeat (3) @(negedge clk);
    chk("reset rdata", rdata, 32'h0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset misaligned", 32'(misaligned), 32'd0);
    chk("reset strobes", {30'd0, bus_re, bus_we}, 32'd0);
    chk("reset bus_addr", bus_addr, 32'h0);
    chk("reset bus_wdata", 32'(bus_wdata), 32'd0);
    rst_n = 1'b1;

    // Both direction bits set: request must be dropped.
    @(negedge clk);
    log_q.delete();
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b1; by = 1'b1; addr = 32'h123;
    @(posedge clk);
    #1 start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ignore_both busy", 32'(busy), 32'd0);
      chk("ignore_both done", 32'(done), 32'd0);
    end
    chk("ignore_both strobes", 32'(log_q.size()), 32'd0);

    for (int i = 0; i < 9; i++) run_access(tab[i], 1'b0, $sformatf("vec%0d", i));

    // start during ACCESS and during DONE must both be ignored.
    run_access(mk(1, 1, 0, 0, 32'h103, 32'h0, 8'h02, 4, 32'hFFFFFF80), 1'b1, "inject");

    // Reset asserted while the third byte of a store is on the bus.
    @(negedge clk);
    log_q.delete(); byte_idx = 0; wait_cnt = 0;
    for (int i = 0; i < 4; i++) wait_tab[i] = 0;
    start = 1'b1; mem_write = 1'b1; by = 1'b0; half = 1'b0;
    addr = 32'h400; wdata = 32'h11223344;
    @(posedge clk);
    #1 start = 1'b0; mem_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid bus_addr before", bus_addr, 32'h402);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid strobe", {30'd0, bus_re, bus_we}, 32'd0);
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_mem[32'h400] = 8'h44; ref_mem[32'h401] = 8'h33;
    model_rdata = 32'h0;
    run_access(mk(1, 1, 0, 0, 32'h103, 32'h0, 8'h00, 2, 32'hFFFFFF80), 1'b0, "after_rst");

    for (int it = 0; it < 40; it++) begin
      int n, w;
      rv.rd = ($urandom_range(0, 1) == 1);
      rv.wr = !rv.rd;
      case ($urandom_range(0, 2))
        0:       begin rv.b = 1'b1; rv.h = 1'b0; end
        1:       begin rv.b = 1'b0; rv.h = 1'b1; end
        default: begin rv.b = 1'b0; rv.h = 1'b0; end
      endcase
      rv.u = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 4) == 0) rv.a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else rv.a = 32'h1000 + 32'($urandom_range(0, 31));
      rv.wd = $urandom;
      rv.waits = 8'($urandom_range(0, 255));
      n = nbytes(rv);
      w = 0;
      for (int i = 0; i < n; i++) w += int'(rv.waits[2*i +: 2]);
      if (is_trap(rv)) begin
        rv.lat = 32'd1;
        rv.rdata = model_rdata;
      end else begin
        rv.lat = 32'(n + w + 1);
        rv.rdata = rv.rd ? load_model(rv.a, n, rv.u) : model_rdata;
      end
      run_access(rv, 1'b0, $sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
